// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: 2-flop synchronised rx, mid-bit sampling, framing-error detection.
// Optional even-parity frame support when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       is_new,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT >> 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_is_new;
  logic            r_frame_err;
  logic            r_busy;
  logic            w_rx_s;
  logic [CW-1:0]   w_limit;
  logic            w_sample;

  // Returns 1 when data plus parity bit do not form even parity.
  function automatic logic even_parity_bad(input logic [7:0] d, input logic p);
    even_parity_bad = (^d) ^ p;
  endfunction

  assign w_rx_s = r_sync[1];

  // Per-state bit-period limit; the start bit uses half a period to land mid-bit.
  always_comb begin
    w_limit = FULL_M1;
    case (r_state)
      S_START: w_limit = HALF_M1;
      default: w_limit = FULL_M1;
    endcase
  end

  assign w_sample = (r_cnt == w_limit);

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // Synchroniser, receive FSM and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= 2'b11;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_is_new    <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_sync      <= {r_sync[0], rx};
      r_is_new    <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_START: begin
          if (w_sample) begin
            r_cnt <= '0;
            r_bit <= 3'd0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_sample) begin
            r_cnt     <= '0;
            r_par_bad <= even_parity_bad(r_shift, w_rx_s);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_sample) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_parity_err <= 1'b1;
              end else begin
                r_data   <= r_shift;
                r_is_new <= 1'b1;
              end
`else
              r_data   <= r_shift;
              r_is_new <= 1'b1;
`endif
            end else begin
              // Stop bit low: flag once, then hold off until the line returns high.
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_BREAK;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign is_new    = r_is_new;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at CLKS_PER_BIT=8; expected strobes are queued by
// the stimulus and matched (kind, data, cycle) by an independent monitor.
module tb_uart_rx_byte;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + (CPB / 2) + 9 * CPB + CPB;
`else
  localparam int LAT = 3 + (CPB / 2) + 9 * CPB;
`endif
  localparam int K_NEW = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       is_new;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int total;
  int bad;
  int cyc;

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t q[$];
  logic [7:0] last_good;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .is_new    (is_new),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (is_new || frame_err || parity_err)) begin
      chk("onehot", 32'(is_new) + 32'(frame_err) + 32'(parity_err), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_strobe", {29'd0, parity_err, frame_err, is_new}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("kind", (is_new ? 32'd0 : (frame_err ? 32'd1 : 32'd2)), 32'(e.kind));
        chk("data", 32'(data), 32'(e.d));
        chk("latency_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Sends one frame starting now; queues the response the receiver should give.
  task automatic send(input logic [7:0] d, input logic stop_ok, input logic par_ok);
    exp_t e;
    logic p;
    e.at = cyc + LAT;
    p = (^d) ^ ~par_ok;
    if (!stop_ok) begin
      e.kind = K_FERR;
      e.d    = last_good;
`ifdef UART_RX_PARITY_EN
    end else if (!par_ok) begin
      e.kind = K_PERR;
      e.d    = last_good;
`endif
    end else begin
      e.kind    = K_NEW;
      e.d       = d;
      last_good = d;
    end
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(p);
`else
    if (p === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop_ok);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    last_good = 8'h00;
    rst_n     = 1'b0;
    rx        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_is_new", 32'(is_new), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Idle line: nothing may happen.
    repeat (200) @(posedge clk);
    #1;
    chk("idle_data", 32'(data), 32'h00);
    chk("idle_busy", 32'(busy), 32'd0);

    // Key then message byte, back to back.
    send(8'h03, 1'b1, 1'b1);
    send(8'hA5, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_data", 32'(data), 32'hA5);

    // Two-cycle glitch must be rejected in START.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    chk("glitch_data", 32'(data), 32'hA5);

    // Framing error, then a held break, then a clean byte.
    send(8'h5A, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("break_busy", 32'(busy), 32'd1);
    chk("break_data", 32'(data), 32'hA5);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("after_break_busy", 32'(busy), 32'd0);
    send(8'h11, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_ferr_data", 32'(data), 32'h11);

    // Reset during bit 4 of 8'hFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_strobes", {29'd0, parity_err, frame_err, is_new}, 32'd0);
    last_good = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send(8'h42, 1'b1, 1'b1);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    send(8'h07, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("parity_good_data", 32'(data), 32'h07);
`endif

    repeat (20) @(posedge clk);
    #1;
    chk("final_data", 32'(data), 32'(last_good));
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
